// File: rtl/sram_port_master_if.sv
// Request/response/memory bus bundle for sram_port_master.
// master modport: the port master (consumes requests and memory read data,
//   drives the memory command and read responses).
// slave modport: the opposite view (request source, memory, response sink).
interface sram_port_master_if #(
  parameter int WORD_SIZE  = 256,
  parameter int NUM_WORDS  = 512,
  parameter int WRITE_SIZE = 8,
  parameter int TAG_W      = 4
);
  localparam int AW = $clog2(NUM_WORDS);
  localparam int MW = WORD_SIZE / WRITE_SIZE;

  logic                 IN_req_valid;
  logic                 IN_req_we;
  logic [AW-1:0]        IN_req_addr;
  logic [WORD_SIZE-1:0] IN_req_data;
  logic [MW-1:0]        IN_req_wm;
  logic [TAG_W-1:0]     IN_req_tag;
  logic                 OUT_req_ready;

  logic                 OUT_nce;
  logic                 OUT_nwe;
  logic [AW-1:0]        OUT_addr;
  logic [WORD_SIZE-1:0] OUT_data;
  logic [MW-1:0]        OUT_wm;
  logic [WORD_SIZE-1:0] IN_mem_rdata;

  logic                 OUT_resp_valid;
  logic [WORD_SIZE-1:0] OUT_resp_data;
  logic [TAG_W-1:0]     OUT_resp_tag;
  logic                 IN_resp_ready;

  modport master (
    input  IN_req_valid, IN_req_we, IN_req_addr, IN_req_data, IN_req_wm, IN_req_tag,
    output OUT_req_ready,
    output OUT_nce, OUT_nwe, OUT_addr, OUT_data, OUT_wm,
    input  IN_mem_rdata,
    output OUT_resp_valid, OUT_resp_data, OUT_resp_tag,
    input  IN_resp_ready
  );

  modport slave (
    output IN_req_valid, IN_req_we, IN_req_addr, IN_req_data, IN_req_wm, IN_req_tag,
    input  OUT_req_ready,
    input  OUT_nce, OUT_nwe, OUT_addr, OUT_data, OUT_wm,
    output IN_mem_rdata,
    input  OUT_resp_valid, OUT_resp_data, OUT_resp_tag,
    output IN_resp_ready
  );
endinterface

// File: rtl/sram_port_master.sv
// SRAM port master: turns a valid/ready request stream into registered
// single-cycle SRAM commands, tracks read latency with a tag shift pipeline
// and returns read data in issue order through a small response FIFO.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   bus (master)  request in (IN_req_*, OUT_req_ready), memory command out
//                 (OUT_nce/nwe/addr/data/wm), memory read data in
//                 (IN_mem_rdata), read response out (OUT_resp_*, IN_resp_ready)
module sram_port_master #(
  parameter int WORD_SIZE  = 256,
  parameter int NUM_WORDS  = 512,
  parameter int WRITE_SIZE = 8,
  parameter int READ_LAT   = 2,
  parameter int RESP_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input logic                clk,
  input logic                rst,
  sram_port_master_if.master bus
);
  localparam int PW = $clog2(RESP_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RESP_DEPTH);

  logic [CW-1:0]        outstanding;
  logic [CW-1:0]        fifo_cnt;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [WORD_SIZE-1:0] fifo_data [RESP_DEPTH];
  logic [TAG_W-1:0]     fifo_tag  [RESP_DEPTH];
  logic [READ_LAT:0]    pipe_v;
  logic [TAG_W-1:0]     pipe_tag  [READ_LAT+1];

  logic accept, rd_accept, push, pop, fifo_empty;

  // Ready depends only on the credit counter (and reset), never on IN_req_*.
  // Credits cover every read from accept to pop, so the FIFO cannot overflow.
  assign bus.OUT_req_ready = ~rst & (outstanding < DEPTH_C);
  assign accept     = bus.IN_req_valid & bus.OUT_req_ready;
  assign rd_accept  = accept & ~bus.IN_req_we;
  assign push       = pipe_v[READ_LAT];
  assign fifo_empty = (fifo_cnt == '0);
  assign pop        = ~fifo_empty & bus.IN_resp_ready;

  assign bus.OUT_resp_valid = ~fifo_empty;
  // Forced to zero when empty so nothing stale shows after reset.
  assign bus.OUT_resp_data  = fifo_empty ? '0 : fifo_data[rd_ptr];
  assign bus.OUT_resp_tag   = fifo_empty ? '0 : fifo_tag[rd_ptr];

  // Memory command: strobes for one cycle, address/data/mask held when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.OUT_nce  <= 1'b1;
      bus.OUT_nwe  <= 1'b1;
      bus.OUT_addr <= '0;
      bus.OUT_data <= '0;
      bus.OUT_wm   <= '0;
    end else if (accept) begin
      bus.OUT_nce  <= 1'b0;
      bus.OUT_nwe  <= ~bus.IN_req_we;
      bus.OUT_addr <= bus.IN_req_addr;
      bus.OUT_data <= bus.IN_req_data;
      bus.OUT_wm   <= bus.IN_req_we ? bus.IN_req_wm : '0;
    end else begin
      bus.OUT_nce  <= 1'b1;
      bus.OUT_nwe  <= 1'b1;
    end
  end

  // Stage 0 loads on the accept edge; the last stage marks the edge at which
  // IN_mem_rdata belongs to that read. Clearing it on reset drops reads in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v <= '0;
      for (int i = 0; i <= READ_LAT; i++) pipe_tag[i] <= '0;
    end else begin
      pipe_v      <= {pipe_v[READ_LAT-1:0], rd_accept};
      pipe_tag[0] <= bus.IN_req_tag;
      for (int i = 1; i <= READ_LAT; i++) pipe_tag[i] <= pipe_tag[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= bus.IN_mem_rdata;
      fifo_tag[wr_ptr]  <= pipe_tag[READ_LAT];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      outstanding <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: ;
      endcase
      unique case ({rd_accept, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase
    end
  end
endmodule
